cache_refill_ctrl: RTL and testbench

//  Miss/refill controller between main data memory and the 4-set direct-mapped data cache.
//  On a CPU access that misses, stalls the pipeline and fetches the 4-word (16-byte) block

---
 rtl/cache_refill_ctrl.sv | 102 ++++++++++
 tb/tb_cache_refill_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// Miss/refill controller: on a cache miss it stalls the pipeline, fetches the 4-word
// block from memory one beat per handshake, then strobes the whole line into the cache.
module cache_refill_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic                  Hit,
    output logic                  mem_rd_en,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid,
    output logic [DATA_WIDTH-1:0] d0,
    output logic [DATA_WIDTH-1:0] d1,
    output logic [DATA_WIDTH-1:0] d2,
    output logic [DATA_WIDTH-1:0] d3,
    output logic                  fill_we,
    output logic [DATA_WIDTH-1:0] fill_addr,
    output logic                  stall,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FILL
    } state_t;

    state_t                state;
    logic [1:0]            beat;
    logic [DATA_WIDTH-5:0] base;
    logic                  miss;
    logic                  unused_a_offset;

    assign miss            = req & ~Hit;
    assign unused_a_offset = ^A[3:0];

    // Addresses are derived from registered base/beat, so they stay stable across memory waits.
    assign mem_addr  = {base, beat, 2'b00};
    assign fill_addr = {base, 4'b0000};
    assign stall     = (state != IDLE) | miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat       <= '0;
            base       <= '0;
            d0         <= '0;
            d1         <= '0;
            d2         <= '0;
            d3         <= '0;
            mem_rd_en  <= 1'b0;
            fill_we    <= 1'b0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fill_we <= 1'b0;
                    if (miss) begin
                        base      <= A[DATA_WIDTH-1:4];
                        beat      <= '0;
                        mem_rd_en <= 1'b1;
                        state     <= FETCH;
                        if (miss_count != '1) begin
                            miss_count <= miss_count + 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (mem_valid) begin
                        case (beat)
                            2'd0:    d0 <= mem_rdata;
                            2'd1:    d1 <= mem_rdata;
                            2'd2:    d2 <= mem_rdata;
                            default: d3 <= mem_rdata;
                        endcase
                        if (beat == 2'd3) begin
                            mem_rd_en <= 1'b0;
                            fill_we   <= 1'b1;
                            state     <= FILL;
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end
                end
                FILL: begin
                    fill_we <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    mem_rd_en <= 1'b0;
                    fill_we   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed scenarios plus randomized refills,
// checked per cycle against a transaction-level model of the expected refill.
module tb_cache_refill_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] A;
    logic        Hit;
    logic        mem_rd_en, mem_rd_en_s;
    logic [31:0] mem_addr, mem_addr_s;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic [31:0] d0, d1, d2, d3;
    logic [31:0] d0_s, d1_s, d2_s, d3_s;
    logic        fill_we, fill_we_s;
    logic [31:0] fill_addr, fill_addr_s;
    logic        stall, stall_s;
    logic [15:0] miss_count;
    logic [1:0]  miss_count_s;

    int n_cmp = 0;
    int n_err = 0;

    int          exp_cnt = 0;
    logic [31:0] exp_d [4];

    cache_refill_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .A(A), .Hit(Hit),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .fill_we(fill_we), .fill_addr(fill_addr), .stall(stall),
        .miss_count(miss_count)
    );

    // Narrow-counter instance shares all inputs; used for saturation checks.
    cache_refill_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req(req), .A(A), .Hit(Hit),
        .mem_rd_en(mem_rd_en_s), .mem_addr(mem_addr_s), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .d0(d0_s), .d1(d1_s), .d2(d2_s), .d3(d3_s),
        .fill_we(fill_we_s), .fill_addr(fill_addr_s), .stall(stall_s),
        .miss_count(miss_count_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        int sat16;
        int sat2;
        sat16 = (exp_cnt > 65535) ? 65535 : exp_cnt;
        sat2  = (exp_cnt > 3) ? 3 : exp_cnt;
        check({tag, "_cnt"}, {16'h0, miss_count}, sat16);
        check({tag, "_cnt2"}, {30'h0, miss_count_s}, sat2);
    endtask

    task automatic check_hold(input string tag);
        check({tag, "_d0"}, d0, exp_d[0]);
        check({tag, "_d1"}, d1, exp_d[1]);
        check({tag, "_d2"}, d2, exp_d[2]);
        check({tag, "_d3"}, d3, exp_d[3]);
    endtask

    // One IDLE cycle with a non-missing access pattern.
    task automatic idle_cycle(input logic r, input logic h);
        @(posedge clk);
        #1;
        req       = r;
        Hit       = h;
        A         = $urandom;
        mem_valid = 1'($urandom);
        mem_rdata = $urandom;
        #1;
        check("idle_stall", stall, 1'b0);
        check("idle_rd_en", mem_rd_en, 1'b0);
        check("idle_fill_we", fill_we, 1'b0);
        check_hold("idle");
        check_counts("idle");
    endtask

    // mode 0: zero-wait memory, 1: valid every 3rd cycle, 2: random waits.
    // abort_at < 4 asserts reset once that many beats have been accepted.
    task automatic do_refill(input logic [31:0] addr, input int mode, input bit addr_data,
                             input bit perturb, input int abort_at);
        logic [31:0] blk;
        logic [31:0] cur;
        logic [31:0] got_d [4];
        int k;
        int c;
        blk = {addr[31:4], 4'h0};
        k   = 0;
        c   = 0;

        @(posedge clk);
        #1;
        req       = 1'b1;
        A         = addr;
        Hit       = 1'b0;
        mem_valid = 1'($urandom);
        mem_rdata = $urandom;
        #1;
        check("det_stall", stall, 1'b1);
        check("det_rd_en", mem_rd_en, 1'b0);
        check("det_fill_we", fill_we, 1'b0);
        check_counts("det");
        exp_cnt++;

        while (k < 4) begin
            @(posedge clk);
            #1;
            if (k == abort_at) begin
                rst_n     = 1'b0;
                req       = 1'b0;
                Hit       = 1'b0;
                mem_valid = 1'b0;
                #1;
                exp_cnt = 0;
                for (int i = 0; i < 4; i++) exp_d[i] = '0;
                check("rst_rd_en", mem_rd_en, 1'b0);
                check("rst_fill_we", fill_we, 1'b0);
                check("rst_stall", stall, 1'b0);
                check("rst_fill_addr", fill_addr, 32'h0);
                check("rst_mem_addr", mem_addr, 32'h0);
                check_hold("rst");
                check_counts("rst");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            cur = blk + 32'(4 * k);
            if (perturb) begin
                req = 1'($urandom);
                Hit = 1'($urandom);
                A   = ($urandom_range(0, 1) == 1) ? 32'h0000_1234 : $urandom;
            end else begin
                req = 1'b0;
                Hit = 1'b0;
            end
            case (mode)
                0:       mem_valid = 1'b1;
                1:       mem_valid = ((c % 3) == 2);
                default: mem_valid = (c >= 60) ? 1'b1 : 1'($urandom);
            endcase
            mem_rdata = addr_data ? cur : $urandom;
            #1;
            check("fetch_rd_en", mem_rd_en, 1'b1);
            check("fetch_addr", mem_addr, cur);
            check("fetch_stall", stall, 1'b1);
            check("fetch_fill_we", fill_we, 1'b0);
            if (mem_valid) begin
                got_d[k] = mem_rdata;
                k++;
            end
            c++;
        end

        @(posedge clk);
        #1;
        req       = perturb ? 1'($urandom) : 1'b0;
        Hit       = 1'($urandom);
        A         = $urandom;
        mem_valid = 1'($urandom);
        mem_rdata = $urandom;
        #1;
        for (int i = 0; i < 4; i++) exp_d[i] = got_d[i];
        check("fill_we", fill_we, 1'b1);
        check("fill_addr", fill_addr, blk);
        check("fill_stall", stall, 1'b1);
        check("fill_rd_en", mem_rd_en, 1'b0);
        check("fill_we_sat", fill_we_s, 1'b1);
        check_hold("fill");
        check_counts("fill");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) exp_d[i] = '0;
        rst_n     = 1'b0;
        req       = 1'b0;
        A         = '0;
        Hit       = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        #2;
        check("reset_rd_en", mem_rd_en, 1'b0);
        check("reset_fill_we", fill_we, 1'b0);
        check("reset_stall", stall, 1'b0);
        check_hold("reset");
        check_counts("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Hits and idle cycles never start a refill.
        for (int i = 0; i < 10; i++) idle_cycle(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) idle_cycle(1'b0, 1'($urandom));

        do_refill(32'h0000_0040, 0, 1'b1, 1'b0, 4);
        idle_cycle(1'b1, 1'b1);
        do_refill(32'h0000_0040, 1, 1'b1, 1'b0, 4);
        idle_cycle(1'b0, 1'b0);
        do_refill(32'h0000_004C, 2, 1'b1, 1'b1, 4);
        idle_cycle(1'b1, 1'b1);

        do_refill(32'h0000_0040, 0, 1'b1, 1'b0, 2);
        for (int i = 0; i < 3; i++) idle_cycle(1'b0, 1'b0);
        do_refill(32'h0000_0080, 0, 1'b1, 1'b0, 4);

        // Back-to-back misses walk the narrow counter into saturation.
        for (int i = 0; i < 4; i++) do_refill($urandom, 0, 1'b0, 1'b0, 4);
        idle_cycle(1'b1, 1'b1);

        for (int n = 0; n < 30; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 1) == 1) idle_cycle(1'b1, 1'b1);
                else idle_cycle(1'b0, 1'($urandom));
            end
            do_refill($urandom, $urandom_range(0, 2), 1'($urandom), 1'($urandom), 4);
        end
        idle_cycle(1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
